fc_sequencer: RTL

//  Control FSM for the pool -> fully-connected (FC) stage of the CNN.
//  - Captures the 12x12 pooled positions into the feature buffer (all 8 channel banks are written in parallel).
//  - Walks the 1152 feature/weight addresses to drive the FC MAC array.
//  - Scans the 10 class accumulators and reports the signed argmax class.
//  - Replaces the free-running pool_done/count logic with a start/busy/done handshake.

---
 rtl/fc_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fc_sequencer.sv
// rtl/fc_sequencer.sv - pool -> fully-connected stage control FSM with argmax
//
// Purpose: captures POOL_X*POOL_Y pooled beats into the feature buffer, walks
// the N = POOL_X*POOL_Y*CHANNELS FC indices for the MAC array, waits MAC_LAT
// cycles for the accumulators to settle, then scans N_CLASS accumulators and
// reports the signed argmax through a start/busy/done handshake.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             begin an image; only honoured in IDLE
//   pool_valid        pooled beat present; count_x/count_y give its position
//   busy              high in every state except IDLE
//   feat_wr_en/addr   registered feature-buffer write (all channel banks)
//   mac_clear         one-cycle accumulator clear at the start of an image
//   mac_en/feat_rd_addr/mac_last  FC walk, index 0..N-1, last flag at N-1
//   score_sel/score_in  accumulator select and its value one cycle later
//   done              one-cycle pulse; class_id/class_score valid and held
module fc_sequencer #(
  parameter int POOL_X    = 12,
  parameter int POOL_Y    = 12,
  parameter int CHANNELS  = 8,
  parameter int N_CLASS   = 10,
  parameter int ACC_WIDTH = 113,
  parameter int MAC_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pool_valid,
  input  logic [4:0]           count_x,
  input  logic [4:0]           count_y,
  output logic                 busy,
  output logic                 feat_wr_en,
  output logic [7:0]           feat_wr_addr,
  output logic                 mac_clear,
  output logic                 mac_en,
  output logic [10:0]          feat_rd_addr,
  output logic                 mac_last,
  output logic [3:0]           score_sel,
  input  logic [ACC_WIDTH-1:0] score_in,
  output logic                 done,
  output logic [3:0]           class_id,
  output logic [ACC_WIDTH-1:0] class_score
);

  localparam int N_BEAT = POOL_X * POOL_Y;
  localparam int N_FC   = POOL_X * POOL_Y * CHANNELS;
  localparam int DW     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_MAC, S_DRAIN, S_SCAN, S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [7:0]           beat_cnt;
  logic [10:0]          rd_idx;
  logic                 mac_primed;
  logic [DW-1:0]        drain_cnt;
  logic [3:0]           sel_cnt;
  logic [ACC_WIDTH-1:0] best_val;
  logic [3:0]           best_idx;

  logic                 in_range;
  logic [7:0]           addr_calc;
  logic                 take;
  logic [ACC_WIDTH-1:0] cand_val;
  logic [3:0]           cand_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CAPTURE;
      S_CAPTURE: if (pool_valid && beat_cnt == 8'(N_BEAT - 1)) state_nxt = S_MAC;
      S_MAC:     if (mac_primed && rd_idx == 11'(N_FC - 1)) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_cnt == DW'(MAC_LAT - 1)) state_nxt = S_SCAN;
      S_SCAN:    if (sel_cnt == 4'(N_CLASS)) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state and counters
  always_comb begin
    busy         = (state != S_IDLE);
    mac_en       = (state == S_MAC) && mac_primed;
    feat_rd_addr = rd_idx;
    mac_last     = mac_en && (rd_idx == 11'(N_FC - 1));
    score_sel    = (state == S_SCAN && sel_cnt < 4'(N_CLASS)) ? sel_cnt : 4'd0;
    done         = (state == S_DONE);
  end

  assign in_range  = (count_x < 5'(POOL_X)) && (count_y < 5'(POOL_Y));
  assign addr_calc = 8'(POOL_Y) * 8'(count_x) + 8'(count_y);

  // Running argmax: the first sample always loads; later samples replace the
  // best only when strictly greater, so ties keep the lower index.
  always_comb begin
    take     = (sel_cnt == 4'd1) || ($signed(score_in) > $signed(best_val));
    cand_val = take ? score_in : best_val;
    cand_idx = take ? (sel_cnt - 4'd1) : best_idx;
  end

  // Counters and datapath registers. Each counter is held at 0 outside its
  // own state so it always starts from 0 on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_wr_en   <= 1'b0;
      feat_wr_addr <= 8'd0;
      mac_clear    <= 1'b0;
      beat_cnt     <= 8'd0;
      rd_idx       <= 11'd0;
      mac_primed   <= 1'b0;
      drain_cnt    <= '0;
      sel_cnt      <= 4'd0;
      best_val     <= '0;
      best_idx     <= 4'd0;
      class_id     <= 4'd0;
      class_score  <= '0;
    end else begin
      feat_wr_en <= 1'b0;
      mac_clear  <= (state == S_IDLE) && start;

      if (state == S_CAPTURE) begin
        if (pool_valid) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (in_range) begin
            feat_wr_en   <= 1'b1;
            feat_wr_addr <= addr_calc;
          end
        end
      end else begin
        beat_cnt <= 8'd0;
      end

      // The final capture write lands in the first MAC cycle, so reading
      // starts one cycle later to see it.
      if (state == S_MAC) begin
        mac_primed <= 1'b1;
        if (mac_primed && rd_idx != 11'(N_FC - 1)) rd_idx <= rd_idx + 11'd1;
      end else begin
        mac_primed <= 1'b0;
        rd_idx     <= 11'd0;
      end

      if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                  drain_cnt <= '0;

      // score_in for select k arrives while sel_cnt == k+1.
      if (state == S_SCAN) begin
        if (sel_cnt != 4'(N_CLASS)) sel_cnt <= sel_cnt + 4'd1;
        if (sel_cnt != 4'd0) begin
          best_val <= cand_val;
          best_idx <= cand_idx;
        end
        if (sel_cnt == 4'(N_CLASS)) begin
          class_id    <= cand_idx;
          class_score <= cand_val;
        end
      end else begin
        sel_cnt <= 4'd0;
      end
    end
  end

endmodule
